// File: rtl/control_sequencer.sv
// Six-T-state control sequencer for a small accumulator machine.
// Fetch in T1-T3, opcode-specific execute in T4-T6, with run/freeze and halt handling.
module control_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_STA = 4'h4,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] bus_in,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       mar_load,
  output logic       ram_output_enable,
  output logic       ram_write_enable,
  output logic       ir_load,
  output logic       ir_out,
  output logic       reg_a_load,
  output logic       reg_a_enable,
  output logic       reg_b_load,
  output logic       alu_enable,
  output logic       alu_subtract,
  output logic       out_load,
  output logic [3:0] ir_addr,
  output logic [3:0] opcode,
  output logic [2:0] tstate,
  output logic       halted
);

  typedef enum logic [2:0] {
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } tstate_e;

  tstate_e    r_tstate;
  tstate_e    w_tstate_next;
  logic [7:0] r_ir;
  logic [7:0] w_ir_next;
  logic       r_halted;
  logic       w_halted_next;
  logic [3:0] w_op;
  logic       w_active;
  logic       w_mem_op;

  assign w_op     = r_ir[7:4];
  assign w_active = run && !r_halted && !reset;
  assign w_mem_op = (w_op == OP_LDA) || (w_op == OP_ADD) ||
                    (w_op == OP_SUB) || (w_op == OP_STA);

  assign ir_addr = r_ir[3:0];
  assign opcode  = w_op;
  assign tstate  = r_tstate;
  assign halted  = r_halted;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tstate <= T1;
      r_ir     <= 8'h00;
      r_halted <= 1'b0;
    end else begin
      r_tstate <= w_tstate_next;
      r_ir     <= w_ir_next;
      r_halted <= w_halted_next;
    end
  end

  // HLT parks the counter at T4; only reset can leave that state.
  always_comb begin
    w_tstate_next = r_tstate;
    w_ir_next     = r_ir;
    w_halted_next = r_halted;
    if (run && !r_halted) begin
      case (r_tstate)
        T1: w_tstate_next = T2;
        T2: w_tstate_next = T3;
        T3: begin
          w_tstate_next = T4;
          w_ir_next     = bus_in;
        end
        T4: begin
          if (w_op == OP_HLT) begin
            w_halted_next = 1'b1;
          end else begin
            w_tstate_next = T5;
          end
        end
        T5: w_tstate_next = T6;
        T6: w_tstate_next = T1;
        default: w_tstate_next = T1;
      endcase
    end
  end

  always_comb begin
    pc_out            = 1'b0;
    pc_inc            = 1'b0;
    mar_load          = 1'b0;
    ram_output_enable = 1'b0;
    ram_write_enable  = 1'b0;
    ir_load           = 1'b0;
    ir_out            = 1'b0;
    reg_a_load        = 1'b0;
    reg_a_enable      = 1'b0;
    reg_b_load        = 1'b0;
    alu_enable        = 1'b0;
    alu_subtract      = 1'b0;
    out_load          = 1'b0;
    if (w_active) begin
      case (r_tstate)
        T1: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T2: pc_inc = 1'b1;
        T3: begin
          ram_output_enable = 1'b1;
          ir_load           = 1'b1;
        end
        T4: begin
          if (w_mem_op) begin
            ir_out   = 1'b1;
            mar_load = 1'b1;
          end else if (w_op == OP_OUT) begin
            reg_a_enable = 1'b1;
            out_load     = 1'b1;
          end
        end
        T5: begin
          if (w_op == OP_LDA) begin
            ram_output_enable = 1'b1;
            reg_a_load        = 1'b1;
          end else if (w_op == OP_ADD) begin
            ram_output_enable = 1'b1;
            reg_b_load        = 1'b1;
          end else if (w_op == OP_SUB) begin
            ram_output_enable = 1'b1;
            reg_b_load        = 1'b1;
            alu_subtract      = 1'b1;
          end else if (w_op == OP_STA) begin
            reg_a_enable     = 1'b1;
            ram_write_enable = 1'b1;
          end
        end
        T6: begin
          if (w_op == OP_ADD) begin
            alu_enable = 1'b1;
            reg_a_load = 1'b1;
          end else if (w_op == OP_SUB) begin
            alu_enable   = 1'b1;
            reg_a_load   = 1'b1;
            alu_subtract = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
